// File: rtl/spi_slave.sv
// SPI mode-0 peripheral: oversampled SCK/SS_n/MOSI, rx holding register, tx buffer with FILL default.
// Optional sticky overrun flag enabled by defining SPI_SLAVE_OVR_EN.
module spi_slave #(
    parameter logic [7:0] FILL = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ssn,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       misoe,
    input  logic [7:0] d,
    input  logic       wr,
    output logic       txrdy,
    output logic [7:0] q,
    output logic       rxrdy,
    input  logic       rd,
    output logic       first,
    output logic       ovr
);

    typedef enum logic [1:0] {WAIT, IDLE, SHIFT} state_t;

    state_t     state;
    logic       ssn_s1, ssn_s2;
    logic       sck_s1, sck_s2, sck_s3;
    logic       mosi_s1, mosi_s2;
    logic [7:0] shift;
    logic [7:0] rxsh;
    logic [2:0] cnt;
    logic       bdone;
    logic       ffirst;
    logic [7:0] txbuf;
    logic       sck_rise, sck_fall;
    logic [7:0] rxbyte;
    logic [7:0] txload;
`ifdef SPI_SLAVE_OVR_EN
    logic       ovr_r;
`endif

    // ssn sync resets low so WAIT only leaves after a genuine deselect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ssn_s1  <= 1'b0;
            ssn_s2  <= 1'b0;
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ssn_s1  <= ssn;
            ssn_s2  <= ssn_s1;
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign rxbyte   = {rxsh[6:0], mosi_s2};
    assign txload   = txrdy ? FILL : txbuf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= WAIT;
            shift  <= FILL;
            rxsh   <= '0;
            cnt    <= '0;
            bdone  <= 1'b0;
            ffirst <= 1'b0;
            txbuf  <= '0;
            txrdy  <= 1'b1;
            q      <= '0;
            rxrdy  <= 1'b0;
            first  <= 1'b0;
            misoe  <= 1'b0;
`ifdef SPI_SLAVE_OVR_EN
            ovr_r  <= 1'b0;
`endif
        end else begin
            if (rd)
                rxrdy <= 1'b0;
`ifdef SPI_SLAVE_OVR_EN
            if (rd && wr)
                ovr_r <= 1'b0;
`endif
            case (state)
                WAIT: begin
                    misoe <= 1'b0;
                    if (ssn_s2)
                        state <= IDLE;
                end
                IDLE: begin
                    misoe <= 1'b0;
                    if (!ssn_s2) begin
                        shift  <= txload;
                        txrdy  <= 1'b1;
                        cnt    <= '0;
                        bdone  <= 1'b0;
                        ffirst <= 1'b1;
                        misoe  <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ssn_s2) begin
                        state <= IDLE;
                        misoe <= 1'b0;
                        cnt   <= '0;
                        bdone <= 1'b0;
                    end else if (sck_rise) begin
                        rxsh <= rxbyte;
                        cnt  <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            q      <= rxbyte;
                            rxrdy  <= 1'b1;
                            first  <= ffirst;
                            ffirst <= 1'b0;
                            bdone  <= 1'b1;
`ifdef SPI_SLAVE_OVR_EN
                            if (rxrdy && !rd)
                                ovr_r <= 1'b1;
`endif
                        end
                    end else if (sck_fall) begin
                        if (cnt != 3'd0) begin
                            shift <= {shift[6:0], 1'b1};
                        end else if (bdone) begin
                            shift <= txload;
                            txrdy <= 1'b1;
                            bdone <= 1'b0;
                        end
                    end
                end
                default: state <= WAIT;
            endcase
            // evaluated on the pre-load txrdy so a same-clock write is kept for the next byte
            if (wr && txrdy) begin
                txbuf <= d;
                txrdy <= 1'b0;
            end
        end
    end

    assign miso = misoe ? shift[7] : 1'b1;

`ifdef SPI_SLAVE_OVR_EN
    assign ovr = ovr_r;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 responder for links where an external controller (MCU/ARM) is the SPI master and the FPGA core is the peripheral.
- Oversamples SCK, SS_n and MOSI on the system clock.
- Delivers received bytes to the core through a holding register with a ready flag.
- Shifts out core-supplied reply bytes, or a fill byte when none is queued.

Parameters:
- FILL, 8'hFF, byte shifted out when no reply byte is queued at a byte boundary.

Ports:
- clock  in  1  system clock; must be at least 8x the SCK frequency.
- reset  in  1  asynchronous, active-high reset.
- ssn    in  1  SPI slave select from master, active low, asynchronous.
- sck    in  1  SPI clock from master, asynchronous; idle low (CPOL=0).
- mosi   in  1  SPI data from master, asynchronous.
- miso   out 1  SPI data to master.
- misoe  out 1  MISO output enable; high only while the slave is selected.
- d      in  8  reply byte from the core.
- wr     in  1  one-clock strobe that loads d into the tx buffer.
- txrdy  out 1  tx buffer empty; the core may write.
- q      out 8  last received byte.
- rxrdy  out 1  q holds an unread byte.
- rd     in  1  one-clock strobe that acknowledges q (clears rxrdy).
- first  out 1  q is the first byte of the current frame; valid while rxrdy.
- ovr    out 1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset values:
  - miso=1, misoe=0, q=0, rxrdy=0, txrdy=1, first=0, ovr=0.
  - Shift register = FILL, bit counter = 0, state = WAIT.
- Input synchronisation:
  - ssn, sck and mosi each pass through 2 flops; a third stage on sck is used for edge detection.
  - An SCK edge is acted on 3 clocks after it reaches the pin. mosi is sampled from its own stage-2 flop on the same clock.
- States:
  - WAIT: entered on reset. Ignores the bus. Goes to IDLE once synced ssn=1, so a frame interrupted by reset is discarded entirely.
  - IDLE: synced ssn=1, misoe=0. On synced ssn falling, loads the shift register from the tx buffer, sets counter=0, sets frame-first=1, goes to SHIFT.
  - SHIFT: misoe=1, miso = shift[7].
    - SCK rising: shift in mosi, counter+1.
    - SCK falling with counter 1..7: shift out the next bit.
    - SCK falling with counter=0 after a completed byte: byte-boundary load.
    - Synced ssn rising: go to IDLE, discard the partial byte (no rxrdy), clear counter.
- Tx buffer:
  - wr with txrdy=1 latches d and sets txrdy=0. wr with txrdy=0 is ignored; the buffer keeps its old value.
  - At frame start and at each byte-boundary load:
    - Shift register gets the buffer if txrdy=0, else FILL.
    - txrdy is set to 1.
  - wr on the same clock as a load: the load uses the pre-wr state. If the buffer was empty, FILL is sent and the written byte is kept for the next byte.
- Rx:
  - On the 8th SCK rising edge (counter wraps 7 to 0): q <= assembled byte, rxrdy <= 1, first <= frame-first, frame-first <= 0.
  - rd clears rxrdy. rd on the same clock as byte completion: the new byte wins, rxrdy stays 1.
  - q is held until the next completed byte.
- Latency: received byte visible on q/rxrdy 3 clocks after the 8th SCK rising edge at the pin.
- Timing margin: the master must hold SS_n low at least 4 clocks before the first SCK rising edge, so the frame-start load of the MSB reaches miso in time.

Optional Feature:
- Macro: SPI_SLAVE_OVR_EN.
- Defined:
  - ovr is set when a byte completes while rxrdy=1 and rd is not asserted that clock.
  - The new byte overwrites q.
  - ovr is cleared only by reset, or by rd asserted together with wr (the clear command).
- Undefined: ovr is tied 0, overwrite is silent, and the rd+wr combination has no extra meaning.

Test Plan:
- Reset then idle bus: miso=1, misoe=0, txrdy=1, rxrdy=0, q=8'h00.
- Frame of 1 byte, master sends 8'hA5, no wr: master receives 8'hFF; q=8'hA5, rxrdy=1, first=1; rd clears rxrdy.
- wr d=8'h3C before ssn falls, then 2 bytes 8'h01, 8'h02:
  - Master receives 8'h3C then 8'hFF; txrdy returns 1 at frame start.
  - Second byte gives q=8'h02 with first=0.
- ssn raised after 5 bits of 8'h77, then a full frame of 8'h10: no rxrdy for the partial byte; q=8'h10, first=1.
- With SPI_SLAVE_OVR_EN, send 8'h11 and 8'h22 with no rd: q=8'h22, ovr=1. rd+wr clears ovr. Without the macro, ovr stays 0.
- Reset asserted mid-byte while ssn stays low, then SCK keeps toggling: no rxrdy until ssn goes high and low again; the next frame is received correctly.
